// File: rtl/toggle_request_ctrl.sv
// toggle_request_ctrl
// Front end for the JK-based T flip-flop in the toggle chain. It synchronises
// and debounces an asynchronous request line, issues one single-cycle t pulse
// per debounced press, and raises a sticky error when the flip-flop q output
// does not change after a pulse.
//
// Build option: define AUTO_REPEAT_EN to re-fire every REPEAT_CYCLES+2 cycles
// while the request stays held. Without it, each press gives exactly one pulse
// and the repeat counter is not built.
module toggle_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic q_fb,
    input  logic err_clr,
    output logic t_out,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        FIRE         = 3'd2,
        CHECK        = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Reject configurations the counters cannot represent.
    generate
        if ((DEBOUNCE_CYCLES == 0) || (DEBOUNCE_CYCLES > 255) ||
            (DEBOUNCE_CYCLES >= (64'd1 << CNT_W)) ||
            (REPEAT_CYCLES == 0) || (REPEAT_CYCLES >= (64'd1 << CNT_W))) begin : g_bad_cfg
            $error("toggle_request_ctrl: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
        end
    endgenerate

    logic             s1_r;
    logic             btn_s_r;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             q_prev_r;
    logic             q_prev_s;
    logic             mismatch_s;
    logic             err_s;
    logic             t_out_r;
    logic             busy_r;
    logic             err_r;

`ifdef AUTO_REPEAT_EN
    // The hold count is compared one below REPEAT_CYCLES because the cycle in
    // which it reaches REPEAT_CYCLES is the one that launches the next FIRE.
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt_r;
    logic [CNT_W-1:0] rcnt_s;
`endif

    // Two-flop synchroniser for the asynchronous request line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r    <= 1'b0;
            btn_s_r <= 1'b0;
        end else begin
            s1_r    <= btn_in;
            btn_s_r <= s1_r;
        end
    end

    // Next-state, counter, capture and error-flag logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        q_prev_s   = q_prev_r;
        mismatch_s = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_s     = rcnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (btn_s_r) begin
                    state_s = DEBOUNCE;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s_r) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (cnt_r >= DEB_TERM) begin
                    state_s  = FIRE;
                    q_prev_s = q_fb;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            FIRE: begin
                // Pulse already committed; a release here cannot cancel it.
                state_s = CHECK;
            end
            CHECK: begin
                // The flip-flop toggled on the edge that ended FIRE.
                mismatch_s = (q_fb == q_prev_r);
                state_s    = WAIT_RELEASE;
`ifdef AUTO_REPEAT_EN
                rcnt_s     = '0;
`endif
            end
            WAIT_RELEASE: begin
                if (!btn_s_r) begin
                    state_s = IDLE;
`ifdef AUTO_REPEAT_EN
                    rcnt_s  = '0;
`endif
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (rcnt_r >= REP_LAST) begin
                        state_s  = FIRE;
                        q_prev_s = q_fb;
                        rcnt_s   = '0;
                    end else begin
                        rcnt_s = rcnt_r + CNT_ONE;
                    end
`else
                    state_s = WAIT_RELEASE;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase

        // A mismatch seen in CHECK outranks a clear in the same cycle.
        if (mismatch_s) begin
            err_s = 1'b1;
        end else if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State, counters and registered outputs; reset aborts any pulse at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            q_prev_r <= 1'b0;
            t_out_r  <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt_r   <= '0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            q_prev_r <= q_prev_s;
            t_out_r  <= (state_s == FIRE);
            busy_r   <= (state_s != IDLE);
            err_r    <= err_s;
`ifdef AUTO_REPEAT_EN
            rcnt_r   <= rcnt_s;
`endif
        end
    end

    assign t_out = t_out_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_toggle_request_ctrl.sv
// Bench for toggle_request_ctrl: directed presses against a behavioural
// downstream T flip-flop; expected pulse cycles go into a scoreboard queue
// that a negedge monitor pops whenever t_out rises.
module tb_toggle_request_ctrl;

    localparam int D = 4;
`ifdef AUTO_REPEAT_EN
    localparam int R = 4;
`else
    localparam int R = 16;
`endif

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic btn_in  = 1'b0;
    logic err_clr = 1'b0;
    logic tie0    = 1'b0;
    logic q_fb;
    logic t_out;
    logic busy;
    logic err;
    logic q_tff;
    logic prev_t  = 1'b0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int e0;

    toggle_request_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .q_fb   (q_fb),
        .err_clr(err_clr),
        .t_out  (t_out),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Posedge counter; at a negedge cyc equals the index of the last posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream T flip-flop.
    always @(posedge clk or posedge reset) begin
        if (reset) q_tff <= 1'b0;
        else if (t_out) q_tff <= ~q_tff;
    end

    assign q_fb = tie0 ? 1'b0 : q_tff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", name, act, expv, $time, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        int n;
        n = 0;
        while ((cyc < target) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        chk("wait_bound", cyc, target);
    endtask

    task automatic press(output int edge0);
        @(negedge clk);
        btn_in = 1'b1;
        edge0  = cyc + 1;
    endtask

    // Monitor: pulse width and pulse timing against the scoreboard.
    always @(negedge clk) begin
        if (prev_t) chk("pulse_width", t_out, 1'b0);
        if (t_out && !prev_t) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                chk("pulse_cycle", cyc, exp_q.pop_front());
            end
        end
        prev_t <= t_out;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state, then idle line
        #12;
        chk("rst_t_out", t_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_err", err, 1'b0);
            chk("idle_t_out", t_out, 1'b0);
        end

        // 2: stable press, single pulse at E0+D+2, q toggles 0->1
        press(e0);
        exp_q.push_back(e0 + D + 2);
        wait_until(e0 + 1);
        chk("s2_busy_sync", busy, 1'b0);
        wait_until(e0 + 2);
        chk("s2_busy_deb", busy, 1'b1);
        wait_until(e0 + 19);
        btn_in = 1'b0;
        chk("s2_q_toggled", q_tff, 1'b1);
        chk("s2_err", err, 1'b0);
        repeat (6) @(negedge clk);
        chk("s2_busy_end", busy, 1'b0);
        chk("s2_sb_empty", exp_q.size(), 0);

        // 3: 3-cycle glitch, no pulse, busy drops on third cycle after release
        press(e0);
        repeat (3) @(negedge clk);
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("s3_busy_mid", busy, 1'b1);
        @(negedge clk);
        chk("s3_busy_end", busy, 1'b0);
        repeat (4) @(negedge clk);

        // 4: q_fb stuck low -> sticky err, clear, clear-vs-mismatch priority
        tie0 = 1'b1;
        press(e0);
        exp_q.push_back(e0 + D + 2);
        wait_until(e0 + D + 3);
        chk("s4_err_before", err, 1'b0);
        wait_until(e0 + D + 4);
        chk("s4_err_set", err, 1'b1);
        wait_until(e0 + 11);
        btn_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("s4_err_sticky", err, 1'b1);
        chk("s4_busy_idle", busy, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("s4_err_clr", err, 1'b0);

        press(e0);
        exp_q.push_back(e0 + D + 2);
        wait_until(e0 + D + 3);
        err_clr = 1'b1;
        wait_until(e0 + D + 4);
        err_clr = 1'b0;
        chk("s4_mismatch_wins", err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("s4_clr_no_mismatch", err, 1'b0);
        btn_in = 1'b0;
        repeat (5) @(negedge clk);
        tie0 = 1'b0;

        // 5a: reset during DEBOUNCE
        press(e0);
        wait_until(e0 + 3);
        chk("s5_busy_deb", busy, 1'b1);
        #2;
        reset  = 1'b1;
        btn_in = 1'b0;
        #1;
        chk("s5a_t_out", t_out, 1'b0);
        chk("s5a_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("s5a_busy_after", busy, 1'b0);

        // 5b: reset during FIRE
        press(e0);
        exp_q.push_back(e0 + D + 2);
        wait_until(e0 + D + 2);
        chk("s5b_t_out_high", t_out, 1'b1);
        #2;
        reset  = 1'b1;
        btn_in = 1'b0;
        #1;
        chk("s5b_t_out_async", t_out, 1'b0);
        chk("s5b_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("s5b_busy_after", busy, 1'b0);
        chk("s5b_t_out_after", t_out, 1'b0);

`ifdef AUTO_REPEAT_EN
        // 6: held 30 cycles, pulses at E0+6, then every R+2 cycles (5 total)
        press(e0);
        for (int k = 0; k < 5; k++) exp_q.push_back(e0 + D + 2 + k * (R + 2));
        wait_until(e0 + 29);
        btn_in = 1'b0;
        repeat (8) @(negedge clk);
        chk("s6_q_odd_toggles", q_tff, 1'b1);
        chk("s6_err", err, 1'b0);
        chk("s6_busy", busy, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
